// File: rtl/ram_2port_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM.
// Optional collision flag: RAM_2PORT_COLLISION_FLAG_EN.
package ram_2port_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_READY
  } t_ram_state;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  function automatic int addr_w(int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit ram_params_ok(
    int width,
    int byte_w,
    int rd_lat
  );
    return (byte_w > 0) && (width > 0) &&
           (width % byte_w == 0) &&
           (rd_lat == 1 || rd_lat == 2);
  endfunction

endpackage

// File: rtl/ram_2port_if.sv
// Write/read/clear bus of the byte-enable dual-port RAM.
// o_Collision exists only with RAM_2PORT_COLLISION_FLAG_EN.
interface ram_2port_if #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int BYTE_W = 8
);
  import ram_2port_pkg::*;

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int AW     = addr_w(DEPTH);

  logic              i_Clear;
  logic              i_Wr_DV;
  logic [AW-1:0]     i_Wr_Addr;
  logic [NBYTES-1:0] i_Wr_BE;
  logic [WIDTH-1:0]  i_Wr_Data;
  logic              i_Rd_En;
  logic [AW-1:0]     i_Rd_Addr;
  logic              o_Rd_DV;
  logic [WIDTH-1:0]  o_Rd_Data;
  logic              o_Ready;
`ifdef RAM_2PORT_COLLISION_FLAG_EN
  logic              o_Collision;
`endif

  modport master (
    output i_Clear,
    output i_Wr_DV,
    output i_Wr_Addr,
    output i_Wr_BE,
    output i_Wr_Data,
    output i_Rd_En,
    output i_Rd_Addr,
`ifdef RAM_2PORT_COLLISION_FLAG_EN
    input  o_Collision,
`endif
    input  o_Rd_DV,
    input  o_Rd_Data,
    input  o_Ready
  );

  modport slave (
    input  i_Clear,
    input  i_Wr_DV,
    input  i_Wr_Addr,
    input  i_Wr_BE,
    input  i_Wr_Data,
    input  i_Rd_En,
    input  i_Rd_Addr,
`ifdef RAM_2PORT_COLLISION_FLAG_EN
    output o_Collision,
`endif
    output o_Rd_DV,
    output o_Rd_Data,
    output o_Ready
  );

endinterface

// File: rtl/ram_2port_lane.sv
// One byte lane of the dual-port RAM: storage, lane write,
// and read-first / write-first read register.
module ram_2port_lane
  import ram_2port_pkg::*;
#(
  parameter int BYTE_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int RDW_MODE = RDW_READ_FIRST
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Wr_En,
  input  logic [AW-1:0]     i_Wr_Addr,
  input  logic [BYTE_W-1:0] i_Wr_Data,
  input  logic              i_Rd_En,
  input  logic [AW-1:0]     i_Rd_Addr,
  output logic [BYTE_W-1:0] o_Rd_Data
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] rd_word;
  logic              rd_in_range;
  logic              rd_bypass;

  // i_Wr_En is only ever raised for in-range addresses
  always_comb begin
    rd_in_range = {1'b0, i_Rd_Addr} < DEPTH_L;
    rd_bypass   = (RDW_MODE == RDW_WRITE_FIRST) &&
                  i_Wr_En && (i_Wr_Addr == i_Rd_Addr);
    rd_word     = '0;
    if (rd_bypass)
      rd_word = i_Wr_Data;
    else if (rd_in_range)
      rd_word = mem[i_Rd_Addr];
  end

  always_ff @(posedge i_Clk) begin
    if (i_Wr_En)
      mem[i_Wr_Addr] <= i_Wr_Data;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      o_Rd_Data <= '0;
    else if (i_Rd_En)
      o_Rd_Data <= rd_word;
  end

endmodule

// File: rtl/ram_2port_be.sv
// Byte-enable dual-port RAM with clear engine and 1/2-cycle reads.
// Optional collision flag: RAM_2PORT_COLLISION_FLAG_EN.
module ram_2port_be
  import ram_2port_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int BYTE_W         = 8,
  parameter int RD_LATENCY     = 1,
  parameter int RDW_MODE       = RDW_READ_FIRST,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic     i_Clk,
  input  logic     i_Rst_L,
  ram_2port_if.slave bus
);

  localparam int NBYTES = WIDTH / BYTE_W;
  localparam int AW     = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic RST_RDY = (CLEAR_ON_RESET == 0);

  if (!ram_params_ok(WIDTH, BYTE_W, RD_LATENCY)) begin : g_bad
    $fatal(1, "ram_2port_be: illegal WIDTH/BYTE_W/RD_LATENCY");
  end

  t_ram_state        state;
  logic [AW-1:0]     clr_cnt;
  logic              ready;
  logic              clearing;
  logic              wr_acc;
  logic              rd_acc;
  logic [NBYTES-1:0] lane_we;
  logic [AW-1:0]     lane_waddr;
  logic [WIDTH-1:0]  lane_wdata;
  logic [WIDTH-1:0]  lane_rdata;
  logic              rd_v1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
      ready   <= RST_RDY;
    end else begin
      unique case (state)
        S_IDLE: begin
          clr_cnt <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state <= S_CLEAR;
          end else begin
            state <= S_READY;
            ready <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_cnt == LAST) begin
            state   <= S_READY;
            ready   <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        S_READY: begin
          if (bus.i_Clear) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    clearing   = (state == S_CLEAR);
    wr_acc     = ready && bus.i_Wr_DV &&
                 ({1'b0, bus.i_Wr_Addr} < DEPTH_L);
    rd_acc     = ready && bus.i_Rd_En;
    lane_we    = {NBYTES{clearing}} |
                 ({NBYTES{wr_acc}} & bus.i_Wr_BE);
    lane_waddr = clearing ? clr_cnt : bus.i_Wr_Addr;
    lane_wdata = clearing ? '0 : bus.i_Wr_Data;
  end

  for (genvar b = 0; b < NBYTES; b++) begin : g_lane
    ram_2port_lane #(
      .BYTE_W   (BYTE_W),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .RDW_MODE (RDW_MODE)
    ) u_lane (
      .i_Clk     (i_Clk),
      .i_Rst_L   (i_Rst_L),
      .i_Wr_En   (lane_we[b]),
      .i_Wr_Addr (lane_waddr),
      .i_Wr_Data (lane_wdata[b*BYTE_W +: BYTE_W]),
      .i_Rd_En   (rd_acc),
      .i_Rd_Addr (bus.i_Rd_Addr),
      .o_Rd_Data (lane_rdata[b*BYTE_W +: BYTE_W])
    );
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      rd_v1 <= 1'b0;
    else
      rd_v1 <= rd_acc;
  end

`ifdef RAM_2PORT_COLLISION_FLAG_EN
  logic col1;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      col1 <= 1'b0;
    else
      col1 <= rd_acc && wr_acc && (|bus.i_Wr_BE) &&
              (bus.i_Wr_Addr == bus.i_Rd_Addr);
  end
`endif

  if (RD_LATENCY == 2) begin : g_lat2
    logic             rd_v2;
    logic [WIDTH-1:0] rd_q;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        rd_v2 <= 1'b0;
        rd_q  <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1)
          rd_q <= lane_rdata;
      end
    end

    assign bus.o_Rd_DV   = rd_v2;
    assign bus.o_Rd_Data = rd_q;

`ifdef RAM_2PORT_COLLISION_FLAG_EN
    logic col2;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)
        col2 <= 1'b0;
      else
        col2 <= col1;
    end

    assign bus.o_Collision = col2;
`endif
  end else begin : g_lat1
    assign bus.o_Rd_DV   = rd_v1;
    assign bus.o_Rd_Data = lane_rdata;
`ifdef RAM_2PORT_COLLISION_FLAG_EN
    assign bus.o_Collision = col1;
`endif
  end

  assign bus.o_Ready = ready;

endmodule
